keygen_scheduler: RTL

//  Time-shares one KeyGen instance between NREQ requesters. Round-robin arbitration picks a request.
//  The block latches its (p,q) pair and checks primality sequentially by trial division.
//  It then pulses KeyGen start, waits for finish (with timeout) and returns e/d/n tagged with the requester id.

---
 rtl/keygen_scheduler.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/keygen_scheduler.sv
// Round-robin scheduler sharing one KeyGen engine among NREQ requesters, with
// trial-division primality screening. Define KEYGEN_CT_PAD_EN for constant grant-to-response latency.
module keygen_scheduler #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 2,
  parameter int TIMEOUT   = 1024,
  parameter int CT_CYCLES = 2048
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_p,
  input  logic [NREQ*WIDTH-1:0]     req_q,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [1:0]                rsp_err,
  output logic [WIDTH-1:0]          rsp_e,
  output logic [2*WIDTH-1:0]        rsp_d,
  output logic [2*WIDTH-1:0]        rsp_n,
  output logic                      kg_start,
  output logic [WIDTH-1:0]          kg_p,
  output logic [WIDTH-1:0]          kg_q,
  input  logic [WIDTH-1:0]          kg_e,
  input  logic [2*WIDTH-1:0]        kg_d,
  input  logic [2*WIDTH-1:0]        kg_n,
  input  logic                      kg_finish,
  output logic                      busy,
  output logic [2:0]                dbg_state
);
  // Handshakes: a request transfers on the cycle req_valid[i] & req_ready[i] are both high;
  // a response transfers on rsp_valid & rsp_ready, and rsp_* stay stable until then.

  localparam int ID_W = $clog2(NREQ);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHK    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
`ifdef KEYGEN_CT_PAD_EN
    , S_PAD  = 3'd5
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [WIDTH-1:0]     p_q, p_d, q_q, q_d;
  logic [WIDTH-1:0]     k_q, k_d;
  logic [WC_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [1:0]           err_q, err_d;
  logic [WIDTH-1:0]     e_q, e_d;
  logic [2*WIDTH-1:0]   d_q, d_d, n_q, n_d;

`ifdef KEYGEN_CT_PAD_EN
  localparam int CT_W = $clog2(CT_CYCLES + 1);
  localparam logic [WIDTH-1:0] K_LAST = WIDTH'((1 << (WIDTH / 2)) - 1);
  logic [CT_W-1:0]      ct_cnt_q, ct_cnt_d;
  logic                 fail_q, fail_d;
  state_t               done_st;
  assign done_st = S_PAD;
`else
  state_t               done_st;
  assign done_st = S_RESP;
`endif

  int                   gsel;
  logic                 gany;
  logic [WIDTH-1:0]     p_sel, q_sel;

  always_comb begin
    gany  = 1'b0;
    gsel  = 0;
    p_sel = '0;
    q_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gany && req_valid[i] && (i == (int'(rr_q) + j) % NREQ)) begin
          gany = 1'b1;
          gsel = i;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (i == gsel) begin
        p_sel = req_p[i*WIDTH +: WIDTH];
        q_sel = req_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // One trial-division step on both operands against divisor k_q.
  logic [2*WIDTH-1:0]   kk;
  logic [WIDTH-1:0]     max_pq;
  logic                 p_bad, q_bad, fail_now;

  always_comb begin
    kk       = (2*WIDTH)'(k_q) * (2*WIDTH)'(k_q);
    max_pq   = (p_q > q_q) ? p_q : q_q;
    p_bad    = (p_q < WIDTH'(2)) ||
               ((kk <= (2*WIDTH)'(p_q)) && (k_q != '0) && ((p_q % k_q) == '0));
    q_bad    = (q_q < WIDTH'(2)) ||
               ((kk <= (2*WIDTH)'(q_q)) && (k_q != '0) && ((q_q % k_q) == '0));
    fail_now = p_bad || q_bad || (p_q == q_q);
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    p_d        = p_q;
    q_d        = q_q;
    k_d        = k_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    e_d        = e_q;
    d_d        = d_q;
    n_d        = n_q;
    req_ready  = '0;
    kg_start   = 1'b0;
`ifdef KEYGEN_CT_PAD_EN
    fail_d     = fail_q;
    ct_cnt_d   = ct_cnt_q;
    if (state_q != S_IDLE && ct_cnt_q != '1) ct_cnt_d = ct_cnt_q + 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (gany && !rst) begin
          req_ready = NREQ'(1) << gsel;
          id_d      = ID_W'(gsel);
          rr_d      = (gsel == NREQ - 1) ? '0 : ID_W'(gsel + 1);
          p_d       = p_sel;
          q_d       = q_sel;
          k_d       = WIDTH'(2);
          err_d     = 2'd0;
          e_d       = '0;
          d_d       = '0;
          n_d       = '0;
          state_d   = S_CHK;
`ifdef KEYGEN_CT_PAD_EN
          fail_d    = 1'b0;
          ct_cnt_d  = CT_W'(1);
`endif
        end
      end
      S_CHK: begin
`ifdef KEYGEN_CT_PAD_EN
        fail_d = fail_q || fail_now;
        if (k_q == K_LAST) begin
          if (fail_q || fail_now) begin
            err_d   = 2'd1;
            state_d = S_PAD;
          end else begin
            state_d = S_LAUNCH;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
`else
        if (fail_now) begin
          err_d   = 2'd1;
          state_d = S_RESP;
        end else if (kk > (2*WIDTH)'(max_pq)) begin
          state_d = S_LAUNCH;
        end else begin
          k_d = k_q + 1'b1;
        end
`endif
      end
      S_LAUNCH: begin
        kg_start   = 1'b1;
        wait_cnt_d = WC_W'(1);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (kg_finish) begin
          e_d     = kg_e;
          d_d     = kg_d;
          n_d     = kg_n;
          err_d   = 2'd0;
          state_d = done_st;
        end else if (wait_cnt_q >= WC_W'(TIMEOUT - 1)) begin
          err_d   = 2'd2;
          e_d     = '0;
          d_d     = '0;
          n_d     = '0;
          state_d = done_st;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
`ifdef KEYGEN_CT_PAD_EN
      S_PAD: begin
        if (ct_cnt_q >= CT_W'(CT_CYCLES - 1)) state_d = S_RESP;
      end
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      p_q        <= '0;
      q_q        <= '0;
      k_q        <= '0;
      wait_cnt_q <= '0;
      err_q      <= '0;
      e_q        <= '0;
      d_q        <= '0;
      n_q        <= '0;
`ifdef KEYGEN_CT_PAD_EN
      ct_cnt_q   <= '0;
      fail_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      p_q        <= p_d;
      q_q        <= q_d;
      k_q        <= k_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      e_q        <= e_d;
      d_q        <= d_d;
      n_q        <= n_d;
`ifdef KEYGEN_CT_PAD_EN
      ct_cnt_q   <= ct_cnt_d;
      fail_q     <= fail_d;
`endif
    end
  end

`ifdef KEYGEN_CT_PAD_EN
`ifndef SYNTHESIS
  // A response entering RESP off the fixed deadline means CT_CYCLES is too small.
  always @(posedge clk) begin
    if (!rst && state_q != S_RESP && state_d == S_RESP &&
        ct_cnt_q != CT_W'(CT_CYCLES - 1))
      $error("keygen_scheduler: constant-latency overrun, CT_CYCLES too small");
  end
`endif
`endif

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
  assign rsp_e     = e_q;
  assign rsp_d     = d_q;
  assign rsp_n     = n_q;
  assign kg_p      = p_q;
  assign kg_q      = q_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
